// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Provides the FSM state encoding and the nibble width.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// fourBitAdder: 4-bit ripple datapath with carry in/out.
// Ports: a_i, b_i, ci_i -> s_o (4 bits), co_o.
module fourBitAdder
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                ci_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                co_o
);

    assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_i}
                       + {{NIBBLE_W{1'b0}}, ci_i};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder: one nibble per cycle through one fourBitAdder.
// Ports: clk, rst_n, start, a, b, cin -> busy, done, sum, cout
// (+ ovf when SERIAL_ADDER_OVF_EN is defined).
module nibble_serial_adder_ctrl
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic                        ovf
`endif
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          carry_q, carry_d, cout_q, cout_d;
    logic [3:0]    na, nb, ns;
    logic          nco, accept, last;

    assign accept = (state_q != ADD) && start;
    assign last   = (idx_q == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = ADD;
            ADD:     if (last) state_d = DONE;
            DONE:    state_d = start ? ADD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state_q == ADD);
        done = (state_q == DONE);
    end

    // Select the current nibble of each captured operand
    always_comb begin
        na = '0;
        nb = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                na = a_q[i*NIBBLE_W +: NIBBLE_W];
                nb = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    fourBitAdder u_add (
        .a_i  (na),
        .b_i  (nb),
        .ci_i (carry_q),
        .s_o  (ns),
        .co_o (nco)
    );

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
        end else if (state_q == ADD) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IW'(i)) sum_d[i*NIBBLE_W +: NIBBLE_W] = ns;
            end
            carry_d = nco;
            idx_d   = last ? '0 : idx_q + IW'(1);
            if (last) cout_d = nco;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB is recovered from the top nibble's bit 3:
    // s3 = a3 ^ b3 ^ c3, so c3 = a3 ^ b3 ^ s3.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ADD && last && !accept) begin
            ovf_d = (a_q[W-1] ^ b_q[W-1] ^ ns[3]) ^ nco;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4).
// Table vectors, corner sequences and random ops vs. an arithmetic model.
module tb_nibble_serial_adder_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mc, output logic [W-1:0] es,
                         output logic ec, output logic eo);
        logic [W:0] full;
        int sr;
        full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        es = full[W-1:0];
        ec = full[W];
        sr = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        eo = (sr > 32767) || (sr < -32768);
    endtask

    task automatic wait_done(output int bc);
        int n;
        bc = 0;
        n = 0;
        while (!done && n < 40) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic run_op(string tag, logic [W-1:0] ta, logic [W-1:0] tb,
                          logic tc, logic [W-1:0] es, logic ec, logic eo);
        int bc;
        a = ta;
        b = tb;
        cin = tc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cin = 1'($urandom);
        wait_done(bc);
        chk($sformatf("%s busy_cycles", tag), bc, N);
        chk($sformatf("%s sum", tag), {16'b0, sum}, {16'b0, es});
        chk($sformatf("%s cout", tag), {31'b0, cout}, {31'b0, ec});
`ifdef SERIAL_ADDER_OVF_EN
        chk($sformatf("%s ovf", tag), {31'b0, ovf}, {31'b0, eo});
`endif
        @(negedge clk);
        chk($sformatf("%s done_pulse", tag), {31'b0, done}, 32'd0);
        chk($sformatf("%s sum_hold", tag), {16'b0, sum}, {16'b0, es});
    endtask

    initial begin
        int bc, dcnt;
        logic [W-1:0] s_cap, es;
        logic ec, eo;
        logic [W-1:0] ra, rb;
        logic rc;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        #12;
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst sum", {16'b0, sum}, 32'd0);
        chk("rst cout", {31'b0, cout}, 32'd0);
        chk("rst ovf", {31'b0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].cin, vecs[i].s, vecs[i].co, vecs[i].ov);
        end

        // Start pulsed mid-ADD must be ignored
        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h0F0F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0;
        s_cap = '0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dcnt++;
                s_cap = sum;
            end
            @(negedge clk);
        end
        chk("ign done_count", dcnt, 1);
        chk("ign sum", {16'b0, s_cap}, 32'h5555);

        // Reset mid-ADD at idx=2
        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort busy_before", {31'b0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort sum", {16'b0, sum}, 32'd0);
        chk("abort cout", {31'b0, cout}, 32'd0);
        chk("abort ovf", {31'b0, ovf}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort no_done", dcnt, 0);
        run_op("restart", 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0);

        // Start held across DONE: back-to-back, no idle gap
        a = 16'h1111;
        b = 16'h2222;
        cin = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a = 16'h0F0F;
        b = 16'h0101;
        cin = 1'b1;
        wait_done(bc);
        chk("b2b first_sum", {16'b0, sum}, 32'h3333);
        chk("b2b first_cout", {31'b0, cout}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b busy_next", {31'b0, busy}, 32'd1);
        chk("b2b done_next", {31'b0, done}, 32'd0);
        wait_done(bc);
        chk("b2b busy_cycles", bc, N);
        chk("b2b second_sum", {16'b0, sum}, 32'h1011);
        chk("b2b second_cout", {31'b0, cout}, 32'd0);
        @(negedge clk);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            model(ra, rb, rc, es, ec, eo);
            run_op($sformatf("rnd%0d", i), ra, rb, rc, es, ec, eo);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
